// File: rtl/drink_pkg.sv
// Shared state encoding and coin values for the drink vending block.
// Optional refund path is enabled with the DRINK_REFUND_EN macro.
package drink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE,
        REFUND
    } state_t;

    localparam logic [1:0] HALF_UNITS = 2'd1;
    localparam logic [1:0] ONE_UNITS  = 2'd2;

    function automatic logic [1:0] coin_value(input logic half,
                                              input logic one);
        return (half ? HALF_UNITS : 2'd0) + (one ? ONE_UNITS : 2'd0);
    endfunction

endpackage

// File: rtl/drink_change_counter.sv
// Loadable down-counter paying out change/refund as half-unit pulses.
// Shared by the CHANGE and REFUND states of drink_vend_param.
module drink_change_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          cout,
    output logic          done
);

    // One pulse per decrement, so cout is high exactly load_val cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            cout  <= 1'b0;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
            cout  <= 1'b1;
        end else begin
            cout  <= 1'b0;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/drink_vend_param.sv
// Parametrised drink vending Moore machine with change payout.
// Define DRINK_REFUND_EN to compile in the cancel/refund path.
module drink_vend_param
    import drink_pkg::*;
#(
    parameter int PRICE = 5,
    parameter int CW    = $clog2(PRICE + 3)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          half,
    input  logic          one,
    input  logic          cancel,
    output logic          out,
    output logic          cout,
    output logic [CW-1:0] change,
    output logic [CW-1:0] credit,
    output logic          busy
);

    state_t        state;
    logic [1:0]    v;
    logic [CW-1:0] sum;
    logic          accepting;
    logic          vend_hit;
    logic          refund_hit;
    logic [CW-1:0] load_val;
    logic          done;

    assign v         = coin_value(half, one);
    assign sum       = credit + CW'(v);
    assign accepting = (state == IDLE) || (state == COLLECT);
    assign vend_hit  = accepting && (sum >= CW'(PRICE));

`ifdef DRINK_REFUND_EN
    // A price-reaching coin in the same cycle takes priority over cancel.
    assign refund_hit = accepting && cancel && !vend_hit &&
                        ((state == COLLECT) || (v != 2'd0));
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign refund_hit    = 1'b0;
`endif

    assign load_val = vend_hit ? sum - CW'(PRICE) : sum;

    drink_change_counter #(
        .CW (CW)
    ) u_change (
        .clk      (clk),
        .reset    (reset),
        .load     (vend_hit || refund_hit),
        .en       (busy),
        .load_val (load_val),
        .count    (change),
        .cout     (cout),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            credit <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            out <= 1'b0;
            unique case (state)
                IDLE, COLLECT: begin
                    if (vend_hit) begin
                        state  <= VEND;
                        credit <= '0;
                        out    <= 1'b1;
                        busy   <= 1'b1;
                    end else if (refund_hit) begin
                        state  <= REFUND;
                        credit <= '0;
                        busy   <= 1'b1;
                    end else if (v != 2'd0) begin
                        state  <= COLLECT;
                        credit <= sum;
                    end
                end
                VEND: begin
                    state <= done ? IDLE : CHANGE;
                    busy  <= !done;
                end
                CHANGE, REFUND: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drink_vend_param.sv
// Scoreboard bench for drink_vend_param with a transaction-level model.
// Define DRINK_REFUND_EN to exercise the refund path.
module tb_drink_vend_param;

    localparam int PRICE = 5;
    localparam int CW    = $clog2(PRICE + 3);

    typedef struct {
        int cyc;
        bit vend;
        int chg;
    } ev_t;

    typedef struct {
        int cyc;
        int credit;
        bit busy;
    } st_t;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          half   = 1'b0;
    logic          one    = 1'b0;
    logic          cancel = 1'b0;
    logic          out;
    logic          cout;
    logic [CW-1:0] change;
    logic [CW-1:0] credit;
    logic          busy;

    drink_vend_param #(
        .PRICE (PRICE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .half   (half),
        .one    (one),
        .cancel (cancel),
        .out    (out),
        .cout   (cout),
        .change (change),
        .credit (credit),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t ev_q[$];
    st_t st_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    bit  refund_en;
    int  m_credit = 0;
    int  m_free   = 0;

    function void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Edge e samples the inputs; a payout of c leaves the block busy for
    // observation cycles e..e+c and makes it accept coins again at e+c+2.
    function void predict(int e, bit h, bit o, bit cn);
        int  s;
        int  c;
        ev_t ev;
        st_t st;
        if (e >= m_free) begin
            s = m_credit + h + 2 * o;
            if (s >= PRICE) begin
                c  = s - PRICE;
                ev = '{cyc: e, vend: 1'b1, chg: c};
                ev_q.push_back(ev);
                for (int i = 1; i <= c; i++) begin
                    ev = '{cyc: e + i, vend: 1'b0, chg: c - i};
                    ev_q.push_back(ev);
                end
                m_credit = 0;
                m_free   = e + c + 2;
            end else if (refund_en && cn && s > 0) begin
                for (int i = 1; i <= s; i++) begin
                    ev = '{cyc: e + i, vend: 1'b0, chg: s - i};
                    ev_q.push_back(ev);
                end
                m_credit = 0;
                m_free   = e + s + 2;
            end else begin
                m_credit = s;
            end
        end
        st = '{cyc: e, credit: m_credit, busy: (e < m_free - 1)};
        st_q.push_back(st);
    endfunction

    task automatic step(input bit h, input bit o, input bit cn);
        @(negedge clk);
        half   = h;
        one    = o;
        cancel = cn;
        predict(cyc + 1, h, o, cn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (mon_en) begin
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                s = st_q.pop_front();
                check("credit", int'(credit), s.credit);
                check("busy", int'(busy), int'(s.busy));
                if (!s.busy) check("idle_change", int'(change), 0);
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                check("missed_pulse", 0, 1);
            end
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e = ev_q.pop_front();
                check("out", int'(out), int'(e.vend));
                check("cout", int'(cout), int'(!e.vend));
                check("change", int'(change), e.chg);
            end else if (out || cout) begin
                check("unexpected_pulse", int'({out, cout}), 0);
            end
        end
    end

    initial begin
`ifdef DRINK_REFUND_EN
        refund_en = 1'b1;
`else
        refund_en = 1'b0;
`endif
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_change", int'(change), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // five half coins: exact price, no change
        repeat (5) step(1'b1, 1'b0, 1'b0);
        idle(3);

        // three one coins: change of one
        repeat (3) step(1'b0, 1'b1, 1'b0);
        idle(4);

        // credit 4 then both coins; held one coin must be discarded
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        idle(4);

        // two one coins then cancel
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(7);
        step(1'b1, 1'b0, 1'b0);
        idle(4);

        // asynchronous reset in the middle of a change payout
        repeat (2) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_cout", int'(cout), 1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_cout", int'(cout), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_change", int'(change), 0);
        check("mid_rst_credit", int'(credit), 0);
        ev_q.delete();
        st_q.delete();
        m_credit = 0;
        m_free   = 0;
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(2);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        idle(3);

        // randomized coin and cancel traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0);
        end
        idle(12);
        check("drained_events", ev_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drink_vend_param.md
# drink_vend_param

Parametrised successor to the fixed-price drink Moore machine. Accepts half-unit and one-unit coins, accumulates credit against a configurable `PRICE`, and issues a one-cycle dispense pulse. Over-payment is returned as a train of half-unit change pulses. An optional cancel path refunds the credit held so far. It sits between the coin-acceptor front end and the dispense/change actuators, and all outputs are registered (Moore).

## Interface
Parameters:
- `PRICE`, default 5: drink price in half-units (5 = 2.5). Legal range is 1 and up.
- `CW`, default `$clog2(PRICE+3)`: width of the credit and change counters.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `half`  in  1  half-unit coin present this cycle (worth 1 unit).
- `one`  in  1  one-unit coin present this cycle (worth 2 units).
- `cancel`  in  1  refund request; functional only with `DRINK_REFUND_EN`.
- `out`  out  1  dispense pulse, high exactly one cycle per vend.
- `cout`  out  1  change pulse; each high cycle returns one half-unit.
- `change`  out  CW  half-units of change or refund still to be paid.
- `credit`  out  CW  current accumulated credit in half-units.
- `busy`  out  1  high in VEND, CHANGE and REFUND; coins are ignored while it is high.

## Operation
- States:
  - IDLE: credit is 0.
  - COLLECT: 0 < credit < PRICE.
  - VEND
  - CHANGE
  - REFUND
- Coin value per sampled cycle is `v = half + 2*one`. When `half` and `one` are both high, 3 units are added.
- IDLE and COLLECT:
  - If `credit+v >= PRICE`: go to VEND and load `change = credit+v-PRICE`.
  - Else if `v > 0`: add `v` to credit and go to COLLECT.
  - Else: hold state.
- VEND:
  - `out=1` and `credit` clears to 0.
  - Next state is CHANGE if `change > 0`, otherwise IDLE.
- CHANGE:
  - `cout=1` every cycle and `change` decrements by 1 each cycle.
  - Go to IDLE on the cycle `change` reaches 0. `cout` is high for exactly the loaded change count.
- Coins sampled while `busy=1` are discarded, not credited.
- Cancel handling (`DRINK_REFUND_EN` only):
  - `cancel` in COLLECT, or in IDLE with `v > 0`, with `credit+v < PRICE`: load `change = credit+v`, clear credit, go to REFUND.
  - REFUND behaves like CHANGE but `out` stays 0.
  - If `credit+v >= PRICE` in the same cycle, the vend wins and `cancel` is ignored.
  - `cancel` in any other state is ignored.
- Arithmetic:
  - Credit never exceeds `PRICE-1` in COLLECT.
  - The largest intermediate value is `PRICE+2`, which `CW` covers. No wrap is possible.
- Reset asserted mid-operation aborts the transaction. Credit and pending change are lost with no payout.

## Timing
- Reset values: state=IDLE, `out=0`, `cout=0`, `change=0`, `credit=0`, `busy=0`. Outputs go low asynchronously on assertion of `reset`.
- Reset release: the first coin is sampled on the first rising edge with `reset=1`.
- Coin-to-dispense latency: `out` rises one cycle after the edge that samples the price-reaching coin.
- Change pulses:
  - The first `cout` follows `out` in the next cycle, and pulses are back-to-back.
  - A full transaction with change `c` occupies 1+`c` busy cycles.
- Refund latency: the first `cout` of a refund appears one cycle after `cancel` is sampled.

## Configuration
- Macro: `DRINK_REFUND_EN`.
- Defined: the REFUND state and the cancel logic are compiled in.
- Undefined: the `cancel` port remains but is ignored, and REFUND is unreachable and not synthesised. Credit then only leaves the block through a vend.

## Structure
- Shared package `drink_pkg` holds:
  - The state typedef (IDLE, COLLECT, VEND, CHANGE, REFUND).
  - Coin value constants: `HALF_UNITS=1`, `ONE_UNITS=2`.
- Sub-module `drink_change_counter`:
  - Loadable down-counter of width `CW`.
  - Emits `cout` while the count is nonzero and reports `done`.
  - Shared by the CHANGE and REFUND states.

## Test plan
All scenarios use PRICE=5.
- Reset pulse mid-CHANGE: `cout`, `out`, `busy` and `change` go to 0 immediately. After release, state is IDLE with credit 0.
- Five consecutive `half` coins: `credit` steps 1,2,3,4, then `out` is high one cycle with `change=0` and `cout` never asserts.
- Three consecutive `one` coins: credit 2,4, then `out` pulses once with `change=1`, followed by exactly one `cout` cycle.
- Credit 4, then `half` and `one` together: vend with `change=2`, followed by two back-to-back `cout` cycles. `one` held high during those cycles is not credited.
- With `DRINK_REFUND_EN` defined, two `one` coins then `cancel`: four `cout` cycles, `out` stays 0, and the block ends in IDLE.
- Same `cancel` stimulus with `DRINK_REFUND_EN` undefined: `cancel` is ignored and credit holds at 4.
